// File: rtl/jts16b_snd_mailbox.sv
// S16B main-CPU -> Z80 sound command mailbox with a one-byte reply register.
// Define JTS16B_SNDFIFO_EN for a DEPTH-entry command FIFO; otherwise a single-byte latch is used.
module jts16b_snd_mailbox #(
  parameter int IRQ_GAP = 4,
  parameter int DEPTH   = 4
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       main_wr,
  input  logic [7:0] main_din,
  input  logic       main_rd,
  output logic [7:0] main_dout,
  output logic [2:0] main_status,
  input  logic       snd_rd,
  output logic [7:0] snd_dout,
  input  logic       snd_wr,
  input  logic [7:0] snd_din,
  output logic       snd_irqn,
  output logic       cmd_pending
);

  if (IRQ_GAP < 1 || IRQ_GAP > 15 || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_chk
    $error("jts16b_snd_mailbox: IRQ_GAP must be 1..15 and DEPTH a power of two in 2..16");
  end

  logic [7:0] snd_dout_q, snd_dout_d;
  logic [7:0] main_dout_q, main_dout_d;
  logic       cmd_pending_q, cmd_pending_d;
  logic       cmd_full_q, cmd_full_d;
  logic       rpl_full_q, rpl_full_d;
  logic       overrun_q, overrun_d;
  logic       snd_irqn_q, snd_irqn_d;
  logic [3:0] gap_q, gap_d;
  logic       pop_ok, gap_load, overrun_set;

  // A read with nothing pending is ignored entirely.
  assign pop_ok = snd_rd & cmd_pending_q;

`ifdef JTS16B_SNDFIFO_EN
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       cmd_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, push_ok;

  always_comb begin
    full     = (cnt_q == CNT_W'(DEPTH));
    push_ok  = main_wr & (~full | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok)
      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop_ok)
      cnt_d = cnt_q - 1'b1;
    cmd_pending_d = (cnt_d != '0);
    cmd_full_d    = (cnt_d == CNT_W'(DEPTH));
    gap_load      = pop_ok & cmd_pending_d;
    overrun_set   = main_wr & full & ~pop_ok;
    snd_dout_d    = snd_dout_q;
    // The new head may be the byte being written this very cycle.
    if (cmd_pending_d)
      snd_dout_d = (push_ok && rd_ptr_d == wr_ptr_q) ? main_din : cmd_mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      cmd_mem[wr_ptr_q] <= main_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  always_comb begin
    cmd_pending_d = main_wr | (cmd_pending_q & ~pop_ok);
    cmd_full_d    = cmd_pending_d;
    // Only a coincident write can leave data behind after a pop.
    gap_load      = pop_ok & main_wr;
    overrun_set   = main_wr & cmd_pending_q & ~pop_ok;
    snd_dout_d    = main_wr ? main_din : snd_dout_q;
  end
`endif

  always_comb begin
    gap_d       = gap_load ? 4'(IRQ_GAP) : ((gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0);
    snd_irqn_d  = ~(cmd_pending_d & (gap_d == 4'd0));
    overrun_d   = overrun_q | overrun_set;
    rpl_full_d  = snd_wr | (rpl_full_q & ~main_rd);
    main_dout_d = snd_wr ? snd_din : main_dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_dout_q    <= 8'h00;
      main_dout_q   <= 8'hFF;
      cmd_pending_q <= 1'b0;
      cmd_full_q    <= 1'b0;
      rpl_full_q    <= 1'b0;
      overrun_q     <= 1'b0;
      snd_irqn_q    <= 1'b1;
      gap_q         <= 4'd0;
    end else begin
      snd_dout_q    <= snd_dout_d;
      main_dout_q   <= main_dout_d;
      cmd_pending_q <= cmd_pending_d;
      cmd_full_q    <= cmd_full_d;
      rpl_full_q    <= rpl_full_d;
      overrun_q     <= overrun_d;
      snd_irqn_q    <= snd_irqn_d;
      gap_q         <= gap_d;
    end
  end

  assign snd_dout    = snd_dout_q;
  assign main_dout   = main_dout_q;
  assign main_status = {overrun_q, rpl_full_q, cmd_full_q};
  assign snd_irqn    = snd_irqn_q;
  assign cmd_pending = cmd_pending_q;

endmodule

// File: tb/tb_jts16b_snd_mailbox.sv
// Scoreboard bench for jts16b_snd_mailbox; follows JTS16B_SNDFIFO_EN to pick FIFO or latch expectations.
module tb_jts16b_snd_mailbox;
  localparam int IRQ_GAP = 4;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       main_wr = 1'b0, main_rd = 1'b0, snd_rd = 1'b0, snd_wr = 1'b0;
  logic [7:0] main_din = 8'h00, snd_din = 8'h00;
  logic [7:0] main_dout, snd_dout;
  logic [2:0] main_status;
  logic       snd_irqn, cmd_pending;

  jts16b_snd_mailbox #(.IRQ_GAP(IRQ_GAP), .DEPTH(DEPTH)) dut (
    .rst(rst), .clk(clk),
    .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd),
    .main_dout(main_dout), .main_status(main_status),
    .snd_rd(snd_rd), .snd_dout(snd_dout),
    .snd_wr(snd_wr), .snd_din(snd_din),
    .snd_irqn(snd_irqn), .cmd_pending(cmd_pending)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  byte unsigned cmd_sb[$];
  byte unsigned rpl_sb[$];
  bit          exp_ovr = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else
      $display("ok   %s = %0h", tag, got);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk_eq({tag, ":snd_dout"}, snd_dout, 8'h00);
    chk_eq({tag, ":main_dout"}, main_dout, 8'hFF);
    chk_eq({tag, ":pending"}, cmd_pending, 0);
    chk_eq({tag, ":status"}, main_status, 3'b000);
    chk_eq({tag, ":irqn"}, snd_irqn, 1);
  endtask

  task automatic chk_cmd_side(input string tag);
    bit exp_full;
`ifdef JTS16B_SNDFIFO_EN
    exp_full = (cmd_sb.size() == DEPTH);
`else
    exp_full = (cmd_sb.size() != 0);
`endif
    chk_eq({tag, ":pending"}, cmd_pending, cmd_sb.size() != 0);
    chk_eq({tag, ":full"}, main_status[0], exp_full);
    chk_eq({tag, ":ovr"}, main_status[2], exp_ovr);
    if (cmd_sb.size() != 0)
      chk_eq({tag, ":head"}, snd_dout, cmd_sb[0]);
  endtask

  // Pop is applied to the model before push so a coincident write always fits.
  task automatic cmd_xfer(input bit do_push, input logic [7:0] b, input bit do_pop, input string tag);
    if (do_pop && cmd_sb.size() != 0)
      chk_eq({tag, ":pop"}, snd_dout, cmd_sb.pop_front());
    if (do_push) begin
`ifdef JTS16B_SNDFIFO_EN
      if (cmd_sb.size() < DEPTH) cmd_sb.push_back(b);
      else exp_ovr = 1'b1;
`else
      if (cmd_sb.size() != 0) begin
        cmd_sb[0] = b;
        exp_ovr = 1'b1;
      end else
        cmd_sb.push_back(b);
`endif
    end
    main_wr  = do_push;
    main_din = b;
    snd_rd   = do_pop;
    step();
    main_wr = 1'b0;
    snd_rd  = 1'b0;
    chk_cmd_side(tag);
  endtask

  task automatic chk_gap(input string tag);
    for (int k = 0; k < IRQ_GAP; k++) begin
      chk_eq({tag, ":irqn_hi"}, snd_irqn, 1);
      step();
    end
    chk_eq({tag, ":irqn_end"}, snd_irqn, cmd_sb.size() == 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) step();
    chk_reset("rst");
    rst = 1'b0;
    step();
    chk_reset("post_rst");

    // Single command, read three cycles later
    cmd_xfer(1'b1, 8'h81, 1'b0, "t2_push");
    chk_eq("t2_irqn", snd_irqn, 0);
    step();
    step();
    cmd_xfer(1'b0, 8'h00, 1'b1, "t2_pop");
    chk_eq("t2_irqn_rel", snd_irqn, 1);

    cmd_xfer(1'b0, 8'h00, 1'b1, "idle_pop");
    chk_eq("idle_dout", snd_dout, 8'h81);

`ifdef JTS16B_SNDFIFO_EN
    for (int i = 1; i <= 5; i++)
      cmd_xfer(1'b1, 8'(i), 1'b0, "t3_push");
    chk_eq("t3_ovr", main_status[2], 1);
    for (int i = 0; i < DEPTH; i++) begin
      cmd_xfer(1'b0, 8'h00, 1'b1, "t3_pop");
      if (cmd_sb.size() != 0) chk_gap("t3_gap");
      else chk_eq("t3_irqn_empty", snd_irqn, 1);
    end
`else
    cmd_xfer(1'b1, 8'h10, 1'b0, "t4_push10");
    cmd_xfer(1'b1, 8'h20, 1'b0, "t4_push20");
    chk_eq("t4_dout", snd_dout, 8'h20);
    chk_eq("t4_ovr", main_status[2], 1);
    cmd_xfer(1'b0, 8'h00, 1'b1, "t4_pop");
    chk_eq("t4_pending", cmd_pending, 0);
`endif

    // Push coincident with pop: data stays, IRQ gap applies
    cmd_xfer(1'b1, 8'h33, 1'b0, "pp_a");
    cmd_xfer(1'b1, 8'h44, 1'b1, "pp_b");
    chk_gap("pp_gap");
    cmd_xfer(1'b0, 8'h00, 1'b1, "pp_c");
    chk_eq("pp_irqn", snd_irqn, 1);

    // Reply path: write beats a coincident read
    snd_wr = 1'b1; snd_din = 8'h5A; main_rd = 1'b1;
    rpl_sb.push_back(8'h5A);
    step();
    snd_wr = 1'b0; main_rd = 1'b0;
    chk_eq("rpl_full_a", main_status[1], 1);
    chk_eq("rpl_pop_a", main_dout, rpl_sb.pop_front());
    main_rd = 1'b1;
    step();
    main_rd = 1'b0;
    chk_eq("rpl_empty", main_status[1], 0);
    chk_eq("rpl_hold", main_dout, 8'h5A);
    snd_wr = 1'b1; snd_din = 8'hC3;
    rpl_sb.push_back(8'hC3);
    step();
    snd_wr = 1'b0;
    chk_eq("rpl_full_b", main_status[1], 1);
    chk_eq("rpl_pop_b", main_dout, rpl_sb.pop_front());

    // Reset in the middle of activity, between clock edges
    cmd_xfer(1'b1, 8'h11, 1'b0, "mr_push1");
    cmd_xfer(1'b1, 8'h22, 1'b0, "mr_push2");
    chk_eq("mr_irqn", snd_irqn, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    cmd_sb.delete();
    exp_ovr = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk_reset("mid_rst_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
